// File: rtl/rv32_decode_queue.sv
// ============================================================================
// rv32_decode_queue
// ----------------------------------------------------------------------------
// Purpose:
//   RV32I decode stage (with optional RV32M) that sits between fetch and the
//   ALU stage. Each accepted instruction is fully decoded combinationally and
//   the decoded bundle is stored in a DEPTH-entry circular queue. This lets
//   fetch keep running while execute is stalled. The head of the queue is
//   presented on the o_* outputs.
//
// Parameters:
//   DEPTH    queue entries (power of two, >= 2)
//   EN_MEXT  1: decode RV32M (funct7 = 0000001); 0: those encodings are illegal
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_valid / o_ready      fetch-side handshake (i_inst, i_pc)
//   o_valid / i_ready      execute-side handshake (head bundle)
//   i_flush                discard every queued entry
//   o_count                queue occupancy
//   o_pc .. o_funct3       head: PC and raw register/funct3 fields
//   o_imm                  head: extended immediate
//   o_alu                  head: one-hot ALU op
//                          (ADD,SUB,SLT,SLTU,XOR,OR,AND,SLL,SRL,SRA,EQ,NEQ,GE,GEU)
//   o_mext                 head: one-hot M op
//                          (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU)
//   o_opcode               head: one-hot opcode class
//                          (RTYPE,ITYPE,LOAD,STORE,BRANCH,JAL,JALR,LUI,AUIPC,
//                           SYSTEM,FENCE)
//   o_exception            head: ILLEGAL, ECALL, EBREAK, MRET
// ============================================================================
module rv32_decode_queue #(
    parameter int DEPTH   = 2,
    parameter bit EN_MEXT = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [31:0]              i_inst,
    input  logic [31:0]              i_pc,
    output logic                     o_valid,
    input  logic                     i_ready,
    input  logic                     i_flush,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [31:0]              o_pc,
    output logic [4:0]               o_rs1_addr,
    output logic [4:0]               o_rs2_addr,
    output logic [4:0]               o_rd_addr,
    output logic [2:0]               o_funct3,
    output logic [31:0]              o_imm,
    output logic [13:0]              o_alu,
    output logic [7:0]               o_mext,
    output logic [10:0]              o_opcode,
    output logic [3:0]               o_exception
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Major opcodes (inst[6:0]); the low two bits 2'b11 are part of the match,
    // so a compressed/invalid low pair can never hit any of these.
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Bit positions inside the one-hot opcode vector
    localparam int OH_RTYPE  = 0;
    localparam int OH_ITYPE  = 1;
    localparam int OH_LOAD   = 2;
    localparam int OH_STORE  = 3;
    localparam int OH_BRANCH = 4;
    localparam int OH_JAL    = 5;
    localparam int OH_JALR   = 6;
    localparam int OH_LUI    = 7;
    localparam int OH_AUIPC  = 8;
    localparam int OH_SYSTEM = 9;
    localparam int OH_FENCE  = 10;

    // Bit positions inside the one-hot ALU vector
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_OR   = 5;
    localparam int ALU_AND  = 6;
    localparam int ALU_SLL  = 7;
    localparam int ALU_SRL  = 8;
    localparam int ALU_SRA  = 9;
    localparam int ALU_EQ   = 10;
    localparam int ALU_NEQ  = 11;
    localparam int ALU_GE   = 12;
    localparam int ALU_GEU  = 13;

    // Bit positions inside the exception vector
    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_MRET    = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic [13:0] alu;
        logic [7:0]  mext;
        logic [10:0] opcode;
        logic [3:0]  exception;
    } bundle_t;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [6:0] opc;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opc    = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];

    logic [10:0] opcode;
    logic [31:0] imm;
    logic [13:0] alu;
    logic [7:0]  mext;
    logic [3:0]  exception;
    logic        is_mext;
    bundle_t     decoded;

    // ------------------------------------------------------------------------
    // Opcode classification
    // ------------------------------------------------------------------------
    always_comb begin
        opcode = '0;
        case (opc)
            OP_RTYPE:  opcode[OH_RTYPE]  = 1'b1;
            OP_ITYPE:  opcode[OH_ITYPE]  = 1'b1;
            OP_LOAD:   opcode[OH_LOAD]   = 1'b1;
            OP_STORE:  opcode[OH_STORE]  = 1'b1;
            OP_BRANCH: opcode[OH_BRANCH] = 1'b1;
            OP_JAL:    opcode[OH_JAL]    = 1'b1;
            OP_JALR:   opcode[OH_JALR]   = 1'b1;
            OP_LUI:    opcode[OH_LUI]    = 1'b1;
            OP_AUIPC:  opcode[OH_AUIPC]  = 1'b1;
            OP_SYSTEM: opcode[OH_SYSTEM] = 1'b1;
            OP_FENCE:  opcode[OH_FENCE]  = 1'b1;
            default:   opcode = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Immediate extraction. SYSTEM/FENCE immediates (CSR number, fence bits)
    // are zero-extended since they are not arithmetic values.
    // ------------------------------------------------------------------------
    always_comb begin
        imm = '0;
        if (opcode[OH_ITYPE] || opcode[OH_LOAD] || opcode[OH_JALR]) begin
            imm = {{20{i_inst[31]}}, i_inst[31:20]};
        end else if (opcode[OH_STORE]) begin
            imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
        end else if (opcode[OH_BRANCH]) begin
            imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                   i_inst[11:8], 1'b0};
        end else if (opcode[OH_JAL]) begin
            imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                   i_inst[30:21], 1'b0};
        end else if (opcode[OH_LUI] || opcode[OH_AUIPC]) begin
            imm = {i_inst[31:12], 12'h000};
        end else if (opcode[OH_SYSTEM] || opcode[OH_FENCE]) begin
            imm = {20'h00000, i_inst[31:20]};
        end
    end

    // ------------------------------------------------------------------------
    // ALU / M-extension operation select. M ops leave o_alu all-zero so the
    // execute stage can steer them to the multiplier/divider unit. With
    // EN_MEXT=0 the funct7=0000001 encodings fall through to the normal
    // RTYPE decode but are flagged illegal below.
    // ------------------------------------------------------------------------
    assign is_mext = EN_MEXT && opcode[OH_RTYPE] && (funct7 == 7'b0000001);

    always_comb begin
        alu  = '0;
        mext = '0;
        if (is_mext) begin
            mext[funct3] = 1'b1;
        end else if (opcode[OH_RTYPE] || opcode[OH_ITYPE]) begin
            case (funct3)
                3'b000: begin
                    if (opcode[OH_RTYPE] && i_inst[30]) alu[ALU_SUB] = 1'b1;
                    else                                alu[ALU_ADD] = 1'b1;
                end
                3'b001: alu[ALU_SLL]  = 1'b1;
                3'b010: alu[ALU_SLT]  = 1'b1;
                3'b011: alu[ALU_SLTU] = 1'b1;
                3'b100: alu[ALU_XOR]  = 1'b1;
                3'b101: begin
                    if (i_inst[30]) alu[ALU_SRA] = 1'b1;
                    else            alu[ALU_SRL] = 1'b1;
                end
                3'b110: alu[ALU_OR]   = 1'b1;
                default: alu[ALU_AND] = 1'b1;
            endcase
        end else if (opcode[OH_BRANCH]) begin
            case (funct3)
                3'b000:  alu[ALU_EQ]   = 1'b1;
                3'b001:  alu[ALU_NEQ]  = 1'b1;
                3'b100:  alu[ALU_SLT]  = 1'b1;
                3'b101:  alu[ALU_GE]   = 1'b1;
                3'b110:  alu[ALU_SLTU] = 1'b1;
                3'b111:  alu[ALU_GEU]  = 1'b1;
                default: alu[ALU_ADD]  = 1'b1;
            endcase
        end else begin
            alu[ALU_ADD] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Exception detection. An unrecognised opcode (which includes any word
    // whose low two bits are not 2'b11) is illegal; the remaining checks
    // catch reserved funct7 patterns on shifts and register-register ops.
    // ------------------------------------------------------------------------
    always_comb begin
        exception = '0;

        if (opcode == '0) begin
            exception[EXC_ILLEGAL] = 1'b1;
        end

        if (opcode[OH_ITYPE] && (funct3 == 3'b001 || funct3 == 3'b101)) begin
            if (i_inst[25]) begin
                exception[EXC_ILLEGAL] = 1'b1;
            end
            if (funct3 == 3'b001 && i_inst[30]) begin
                exception[EXC_ILLEGAL] = 1'b1;
            end
        end

        if (opcode[OH_RTYPE]) begin
            case (funct7)
                7'b0000000: ;
                7'b0100000: begin
                    if (funct3 != 3'b000 && funct3 != 3'b101) begin
                        exception[EXC_ILLEGAL] = 1'b1;
                    end
                end
                7'b0000001: begin
                    if (!EN_MEXT) begin
                        exception[EXC_ILLEGAL] = 1'b1;
                    end
                end
                default: exception[EXC_ILLEGAL] = 1'b1;
            endcase
        end

        if (opcode[OH_SYSTEM] && funct3 == 3'b000) begin
            case (i_inst[21:20])
                2'b00:   exception[EXC_ECALL]  = 1'b1;
                2'b01:   exception[EXC_EBREAK] = 1'b1;
                2'b10:   exception[EXC_MRET]   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        decoded.pc        = i_pc;
        decoded.rs1       = i_inst[19:15];
        decoded.rs2       = i_inst[24:20];
        decoded.rd        = i_inst[11:7];
        decoded.funct3    = funct3;
        decoded.imm       = imm;
        decoded.alu       = alu;
        decoded.mext      = mext;
        decoded.opcode    = opcode;
        decoded.exception = exception;
    end

    // ------------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------------
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    bundle_t       mem [DEPTH];
    bundle_t       head;

    // o_ready is a pure function of occupancy, so a full queue cannot accept
    // even when the head is popped in the same cycle.
    assign o_ready = (count != FULL);
    assign o_valid = (count != '0);
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;

    // Pointer and occupancy update; reset beats flush, flush beats traffic.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Payload storage needs no reset: the head is gated whenever count==0.
    always_ff @(posedge i_clk) begin
        if (push && i_rst_n) begin
            mem[wr_ptr] <= decoded;
        end
    end

    assign head = o_valid ? mem[rd_ptr] : '0;

    assign o_count     = count;
    assign o_pc        = head.pc;
    assign o_rs1_addr  = head.rs1;
    assign o_rs2_addr  = head.rs2;
    assign o_rd_addr   = head.rd;
    assign o_funct3    = head.funct3;
    assign o_imm       = head.imm;
    assign o_alu       = head.alu;
    assign o_mext      = head.mext;
    assign o_opcode    = head.opcode;
    assign o_exception = head.exception;

endmodule

// File: tb/tb_rv32_decode_queue.sv
// ============================================================================
// tb_rv32_decode_queue
// ----------------------------------------------------------------------------
// Self-checking bench for rv32_decode_queue (DEPTH=2). Two copies are driven
// from the same inputs: one with RV32M decode enabled and one without, so
// the M-extension encodings can be checked both ways.
// Decode checks are table-driven: each record holds an instruction and its
// hand-decoded head outputs. Queue behaviour (fill/backpressure, same-cycle
// push+pop, flush, reset mid-traffic) is covered by short directed sequences.
// ============================================================================
module tb_rv32_decode_queue;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ready_in;
    logic        flush;

    logic        ready_out,  ready_out_nom;
    logic        valid_out,  valid_out_nom;
    logic [1:0]  count,      count_nom;
    logic [31:0] head_pc,    head_pc_nom;
    logic [4:0]  rs1,        rs1_nom;
    logic [4:0]  rs2,        rs2_nom;
    logic [4:0]  rd,         rd_nom;
    logic [2:0]  funct3,     funct3_nom;
    logic [31:0] imm,        imm_nom;
    logic [13:0] alu,        alu_nom;
    logic [7:0]  mext,       mext_nom;
    logic [10:0] opcode,     opcode_nom;
    logic [3:0]  exc,        exc_nom;

    int checks   = 0;
    int failures = 0;

    rv32_decode_queue #(.DEPTH(2), .EN_MEXT(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(ready_out),
        .i_inst(inst), .i_pc(pc), .o_valid(valid_out), .i_ready(ready_in),
        .i_flush(flush), .o_count(count), .o_pc(head_pc), .o_rs1_addr(rs1),
        .o_rs2_addr(rs2), .o_rd_addr(rd), .o_funct3(funct3), .o_imm(imm),
        .o_alu(alu), .o_mext(mext), .o_opcode(opcode), .o_exception(exc)
    );

    rv32_decode_queue #(.DEPTH(2), .EN_MEXT(1'b0)) dut_nom (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(ready_out_nom),
        .i_inst(inst), .i_pc(pc), .o_valid(valid_out_nom), .i_ready(ready_in),
        .i_flush(flush), .o_count(count_nom), .o_pc(head_pc_nom),
        .o_rs1_addr(rs1_nom), .o_rs2_addr(rs2_nom), .o_rd_addr(rd_nom),
        .o_funct3(funct3_nom), .o_imm(imm_nom), .o_alu(alu_nom),
        .o_mext(mext_nom), .o_opcode(opcode_nom), .o_exception(exc_nom)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    typedef struct {
        logic [31:0] inst;
        logic [10:0] opcode;
        logic [13:0] alu;
        logic [7:0]  mext;
        logic [3:0]  exc;
        logic [3:0]  exc_nom;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Offer one instruction for a single cycle, then sample just after the edge
    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] addr);
        valid_in = 1'b1;
        inst     = word;
        pc       = addr;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inst, opcode, alu, mext, exc, exc_nom, imm, rd, rs1, rs2, funct3
        vecs[0]  = '{32'h00500093, 11'h002, 14'h0001, 8'h00, 4'h0, 4'h0, 32'h00000005,  1, 0,  5, 0};
        vecs[1]  = '{32'h402081B3, 11'h001, 14'h0002, 8'h00, 4'h0, 4'h0, 32'h00000000,  3, 1,  2, 0};
        vecs[2]  = '{32'h027302B3, 11'h001, 14'h0000, 8'h01, 4'h0, 4'h1, 32'h00000000,  5, 6,  7, 0};
        vecs[3]  = '{32'h00000073, 11'h200, 14'h0001, 8'h00, 4'h2, 4'h2, 32'h00000000,  0, 0,  0, 0};
        vecs[4]  = '{32'h00100073, 11'h200, 14'h0001, 8'h00, 4'h4, 4'h4, 32'h00000001,  0, 0,  1, 0};
        vecs[5]  = '{32'h00000000, 11'h000, 14'h0001, 8'h00, 4'h1, 4'h1, 32'h00000000,  0, 0,  0, 0};
        vecs[6]  = '{32'hFFC0A103, 11'h004, 14'h0001, 8'h00, 4'h0, 4'h0, 32'hFFFFFFFC,  2, 1, 28, 2};
        vecs[7]  = '{32'hFE20AC23, 11'h008, 14'h0001, 8'h00, 4'h0, 4'h0, 32'hFFFFFFF8, 24, 1,  2, 2};
        vecs[8]  = '{32'hFE20CEE3, 11'h010, 14'h0004, 8'h00, 4'h0, 4'h0, 32'hFFFFFFFC, 29, 1,  2, 4};
        vecs[9]  = '{32'h008000EF, 11'h020, 14'h0001, 8'h00, 4'h0, 4'h0, 32'h00000008,  1, 0,  8, 0};
        vecs[10] = '{32'h123452B7, 11'h080, 14'h0001, 8'h00, 4'h0, 4'h0, 32'h12345000,  5, 8,  3, 5};
        vecs[11] = '{32'h4020D193, 11'h002, 14'h0200, 8'h00, 4'h0, 4'h0, 32'h00000402,  3, 1,  2, 5};
        vecs[12] = '{32'h02209193, 11'h002, 14'h0080, 8'h00, 4'h1, 4'h1, 32'h00000022,  3, 1,  2, 1};
        vecs[13] = '{32'h4020C1B3, 11'h001, 14'h0010, 8'h00, 4'h1, 4'h1, 32'h00000000,  3, 1,  2, 4};
        vecs[14] = '{32'h30200073, 11'h200, 14'h0001, 8'h00, 4'h8, 4'h8, 32'h00000302,  0, 0,  2, 0};
        vecs[15] = '{32'h027352B3, 11'h001, 14'h0000, 8'h20, 4'h0, 4'h1, 32'h00000000,  5, 6,  7, 5};
        vecs[16] = '{32'h00500091, 11'h000, 14'h0001, 8'h00, 4'h1, 4'h1, 32'h00000000,  1, 0,  5, 0};

        // ---------------- reset (push offered during reset is ignored) -------
        rst_n    = 1'b0;
        valid_in = 1'b1;
        inst     = 32'h00500093;
        pc       = 32'h00000040;
        ready_in = 1'b0;
        flush    = 1'b0;
        stepCycle();
        stepCycle();
        valid_in = 1'b0;
        checkOutput("reset count",  32'(count), 32'd0);
        checkOutput("reset valid",  32'(valid_out), 32'd0);
        checkOutput("reset ready",  32'(ready_out), 32'd1);
        checkOutput("reset pc",     head_pc, 32'd0);
        checkOutput("reset opcode", 32'(opcode), 32'd0);
        checkOutput("reset alu",    32'(alu), 32'd0);
        rst_n = 1'b1;
        stepCycle();

        // ---------------- table-driven decode ----------------
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].inst, 32'h00001000 + 32'(i * 4));
            checkOutput($sformatf("v%0d valid", i),   32'(valid_out), 32'd1);
            checkOutput($sformatf("v%0d count", i),   32'(count), 32'd1);
            checkOutput($sformatf("v%0d pc", i),      head_pc, 32'h00001000 + 32'(i * 4));
            checkOutput($sformatf("v%0d opcode", i),  32'(opcode), 32'(vecs[i].opcode));
            checkOutput($sformatf("v%0d alu", i),     32'(alu), 32'(vecs[i].alu));
            checkOutput($sformatf("v%0d mext", i),    32'(mext), 32'(vecs[i].mext));
            checkOutput($sformatf("v%0d exc", i),     32'(exc), 32'(vecs[i].exc));
            checkOutput($sformatf("v%0d exc_nom", i), 32'(exc_nom), 32'(vecs[i].exc_nom));
            checkOutput($sformatf("v%0d imm", i),     imm, vecs[i].imm);
            checkOutput($sformatf("v%0d rd", i),      32'(rd), 32'(vecs[i].rd));
            checkOutput($sformatf("v%0d rs1", i),     32'(rs1), 32'(vecs[i].rs1));
            checkOutput($sformatf("v%0d rs2", i),     32'(rs2), 32'(vecs[i].rs2));
            checkOutput($sformatf("v%0d funct3", i),  32'(funct3), 32'(vecs[i].funct3));
            ready_in = 1'b1;
            stepCycle();
            ready_in = 1'b0;
            checkOutput($sformatf("v%0d drained", i), 32'(count), 32'd0);
        end

        // ---------------- fill, backpressure, in-order drain ----------------
        applyStimulus(32'h00500093, 32'h00000100);
        applyStimulus(32'h402081B3, 32'h00000104);
        valid_in = 1'b1;
        inst     = 32'h00000073;
        pc       = 32'h00000108;
        checkOutput("full count", 32'(count), 32'd2);
        checkOutput("full ready", 32'(ready_out), 32'd0);
        checkOutput("full head",  head_pc, 32'h00000100);
        stepCycle();
        checkOutput("held count", 32'(count), 32'd2);
        checkOutput("held head",  head_pc, 32'h00000100);
        ready_in = 1'b1;
        stepCycle();
        checkOutput("pop1 pc",    head_pc, 32'h00000104);
        checkOutput("pop1 count", 32'(count), 32'd1);
        checkOutput("pop1 ready", 32'(ready_out), 32'd1);
        stepCycle();
        valid_in = 1'b0;
        checkOutput("pushpop pc",    head_pc, 32'h00000108);
        checkOutput("pushpop count", 32'(count), 32'd1);
        checkOutput("pushpop exc",   32'(exc), 32'h2);
        stepCycle();
        ready_in = 1'b0;
        checkOutput("empty count", 32'(count), 32'd0);
        checkOutput("empty valid", 32'(valid_out), 32'd0);
        checkOutput("empty pc",    head_pc, 32'd0);

        // ---------------- flush with same-cycle push and pop ----------------
        applyStimulus(32'h00500093, 32'h00000200);
        applyStimulus(32'h00500093, 32'h00000204);
        checkOutput("preflush count", 32'(count), 32'd2);
        flush    = 1'b1;
        valid_in = 1'b1;
        ready_in = 1'b1;
        inst     = 32'h00100073;
        pc       = 32'h00000208;
        stepCycle();
        flush    = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        checkOutput("flush count", 32'(count), 32'd0);
        checkOutput("flush valid", 32'(valid_out), 32'd0);
        checkOutput("flush ready", 32'(ready_out), 32'd1);
        stepCycle();
        checkOutput("flush dropped", 32'(count), 32'd0);

        // pointers restart cleanly after flush
        applyStimulus(32'h00100073, 32'h00000300);
        checkOutput("postflush pc",  head_pc, 32'h00000300);
        checkOutput("postflush exc", 32'(exc), 32'h4);

        // ---------------- reset mid-traffic, dominating flush and push -------
        rst_n    = 1'b0;
        flush    = 1'b1;
        valid_in = 1'b1;
        inst     = 32'h00500093;
        stepCycle();
        rst_n    = 1'b1;
        flush    = 1'b0;
        valid_in = 1'b0;
        checkOutput("midreset count", 32'(count), 32'd0);
        checkOutput("midreset valid", 32'(valid_out), 32'd0);
        checkOutput("midreset nom",   32'(count_nom), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
